note_recorder: RTL and testbench

NOTE_RECORDER -- requirements
Module: note_recorder

---
 rtl/note_recorder.sv | 150 +++++++++++++++
 tb/tb_note_recorder.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/note_recorder.sv
// Key-release note recorder: arms on rec_en, timestamps notes in ticks
// and queues {note, gap} entries in a first-word fall-through FIFO.
module note_recorder #(
  parameter int NUM_KEYS = 8,
  parameter int DEPTH    = 16,
  parameter int GAP_W    = 16,
  parameter int TICK_DIV = 100000,
  localparam int NW = $clog2(NUM_KEYS),
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] key_pulse,
  input  logic                rec_en,
  input  logic                clear,
  input  logic                rd_ready,
  output logic                out_valid,
  output logic [NW-1:0]       out_note,
  output logic [GAP_W-1:0]    out_gap,
  output logic [CW-1:0]       count,
  output logic                full,
  output logic                empty,
  output logic                overflow,
  output logic                collide
);

  localparam int AW = $clog2(DEPTH);
  localparam int DW = $clog2(TICK_DIV);

  typedef enum logic [1:0] {IDLE, ARMED, RECORD} state_t;

  state_t              r_state;
  state_t              w_next;
  logic [DW-1:0]       r_div;
  logic [GAP_W-1:0]    r_gap;
  logic [AW-1:0]       r_wp;
  logic [AW-1:0]       r_rp;
  logic [CW-1:0]       r_cnt;
  logic                r_ovf;
  logic                r_col;
  logic [NW+GAP_W-1:0] r_mem [DEPTH];

  logic                w_active;
  logic                w_event;
  logic                w_multi;
  logic                w_pop;
  logic                w_push;
  logic                w_tick;
  logic [NW-1:0]       w_note;
  logic [GAP_W-1:0]    w_wgap;

  assign w_active = (r_state != IDLE);
  assign w_event  = w_active & (|key_pulse);
  assign w_multi  = |(key_pulse & (key_pulse - NUM_KEYS'(1)));
  assign w_tick   = w_active && (r_div == DW'(TICK_DIV - 1));
  assign w_wgap   = (r_state == RECORD) ? r_gap : '0;

  assign empty     = (r_cnt == '0);
  assign full      = (r_cnt == CW'(DEPTH));
  assign count     = r_cnt;
  assign out_valid = !empty;
  assign overflow  = r_ovf;
  assign collide   = r_col;
  assign w_pop     = out_valid & rd_ready;
  // A full FIFO still takes a note when the head leaves in the same cycle
  assign w_push    = w_event & (!full | w_pop);

  assign {out_note, out_gap} = r_mem[r_rp];

  always_comb begin
    w_note = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (key_pulse[i]) w_note = NW'(i);
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (rec_en) w_next = ARMED;
      ARMED: begin
        if (!rec_en)     w_next = IDLE;
        else if (w_push) w_next = RECORD;
      end
      RECORD:  if (!rec_en) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        r_state <= IDLE;
    else if (clear) r_state <= IDLE;
    else            r_state <= w_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         r_div <= '0;
    else if (clear || !w_active)     r_div <= '0;
    else if (w_tick)                 r_div <= '0;
    else                             r_div <= r_div + DW'(1);
  end

  // Gap is held at zero until the first note, so ARMED needs no extra clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_gap <= '0;
    else if (clear || r_state == IDLE || w_push)
      r_gap <= '0;
    else if (r_state == RECORD && w_tick && r_gap != '1)
      r_gap <= r_gap + GAP_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else if (clear) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + AW'(1);
      if (w_pop)  r_rp <= r_rp + AW'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!clear && w_push) r_mem[r_wp] <= {w_note, w_wgap};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf <= 1'b0;
      r_col <= 1'b0;
    end else if (clear) begin
      r_ovf <= 1'b0;
      r_col <= 1'b0;
    end else begin
      if (w_event && w_multi) r_col <= 1'b1;
      if (w_event && !w_push) r_ovf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_note_recorder.sv
// Scoreboard bench for note_recorder: tick-arithmetic reference model,
// directed scenarios, then randomized traffic.
`timescale 1ns/1ps
module tb_note_recorder;

  localparam int NK  = 8;
  localparam int DEP = 16;
  localparam int GW  = 16;
  localparam int TD  = 4;
  localparam longint GMAX = (64'd1 << GW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NK-1:0] kp = '0;
  logic          rec_en = 1'b0;
  logic          clr = 1'b0;
  logic          rr = 1'b0;
  logic          out_valid;
  logic [2:0]    out_note;
  logic [GW-1:0] out_gap;
  logic [4:0]    count;
  logic          full;
  logic          empty;
  logic          overflow;
  logic          collide;

  logic [NK-1:0] s_kp = '0;
  logic          s_rec = 1'b0;
  logic          s_clr = 1'b0;
  logic          s_rr = 1'b0;
  logic          s_valid;
  logic [2:0]    s_note;
  logic [3:0]    s_gap;
  logic [2:0]    s_count;
  logic          s_full;
  logic          s_empty;
  logic          s_ovf;
  logic          s_col;

  note_recorder #(.NUM_KEYS(NK), .DEPTH(DEP), .GAP_W(GW), .TICK_DIV(TD)) dut (
    .clk(clk), .rst(rst), .key_pulse(kp), .rec_en(rec_en),
    .clear(clr), .rd_ready(rr), .out_valid(out_valid),
    .out_note(out_note), .out_gap(out_gap), .count(count),
    .full(full), .empty(empty), .overflow(overflow), .collide(collide)
  );

  // Narrow gap field so saturation is reachable in a short run
  note_recorder #(.NUM_KEYS(NK), .DEPTH(4), .GAP_W(4), .TICK_DIV(2)) u_sat (
    .clk(clk), .rst(rst), .key_pulse(s_kp), .rec_en(s_rec),
    .clear(s_clr), .rd_ready(s_rr), .out_valid(s_valid),
    .out_note(s_note), .out_gap(s_gap), .count(s_count),
    .full(s_full), .empty(s_empty), .overflow(s_ovf), .collide(s_col)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  logic [18:0] exp_q[$];
  logic [18:0] got_q[$];

  task automatic chk(string nm, longint act, longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  // Monitor: every handshake pops the oldest expected entry
  always @(negedge clk) begin
    logic [18:0] e;
    if (!rst && out_valid && rr) begin
      got_q.push_back({out_note, out_gap});
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_unexpected actual=%0d required=none",
                 {out_note, out_gap});
      end else begin
        e = exp_q.pop_front();
        chk("sb_note", out_note, e[18:16]);
        chk("sb_gap", out_gap, e[15:0]);
      end
    end
  end

  // Reference model: cycle k is the interval after clock edge k
  longint k = 0;
  int     m_st = 0;
  longint m_a = 0;
  longint m_w = 0;
  int     m_cnt = 0;
  bit     m_ovf = 1'b0;
  bit     m_col = 1'b0;

  function automatic longint ticks_upto(longint x);
    if (x < m_a) return 0;
    return (x - m_a + 1) / TD;
  endfunction

  always begin
    logic [9:0] st_a;
    logic [9:0] st_e;
    bit         pop;
    bit         acc;
    int         n;
    longint     g;
    @(negedge clk);
    #1;
    if (rst) begin
      m_st = 0; m_cnt = 0; m_ovf = 0; m_col = 0;
      exp_q.delete();
    end
    st_a = {count, empty, full, out_valid, overflow, collide};
    st_e = {m_cnt[4:0], m_cnt == 0, m_cnt == DEP, m_cnt != 0, m_ovf, m_col};
    chk("status", st_a, st_e);
    if (!rst) begin
      pop = (m_cnt > 0) && rr;
      if (clr) begin
        m_st = 0; m_cnt = 0; m_ovf = 0; m_col = 0;
        exp_q.delete();
      end else begin
        acc = 0;
        if (m_st != 0 && kp != 0) begin
          n = 0;
          for (int i = NK - 1; i >= 0; i--) if (kp[i]) n = i;
          if ($countones(kp) > 1) m_col = 1;
          if (m_cnt < DEP || pop) begin
            acc = 1;
            g = (m_st == 1) ? 0 : ticks_upto(k - 1) - ticks_upto(m_w);
            if (g > GMAX) g = GMAX;
            exp_q.push_back({n[2:0], g[15:0]});
            m_w = k;
          end else begin
            m_ovf = 1;
          end
        end
        m_cnt = m_cnt + int'(acc) - int'(pop);
        if (m_st == 0) begin
          if (rec_en) begin m_st = 1; m_a = k + 1; end
        end else if (!rec_en) m_st = 0;
        else if (m_st == 1 && acc) m_st = 2;
      end
    end
    k++;
  end

  task automatic cyc(int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pulse(logic [NK-1:0] v);
    kp = v;
    cyc();
    kp = '0;
  endtask

  function automatic logic [NK-1:0] onehot();
    logic [NK-1:0] one = 1;
    return one << $urandom_range(0, NK - 1);
  endfunction

  task automatic drain(string nm);
    int b = 0;
    rr = 1'b1;
    while (out_valid && b < 60) begin cyc(); b++; end
    chk({nm, "_drain_timeout"}, out_valid, 0);
  endtask

  initial begin
    int r;
    cyc(3);
    rst = 1'b0;
    cyc(2);

    rec_en = 1'b1; rr = 1'b1;
    cyc(2);
    pulse(8'h08);
    cyc(39);
    pulse(8'h20);
    cyc(10);
    chk("two_entries", got_q.size(), 2);
    if (got_q.size() >= 2) begin
      chk("first_note", got_q[0][18:16], 3);
      chk("first_gap", got_q[0][15:0], 0);
      chk("second_note", got_q[1][18:16], 5);
      chk("second_gap", got_q[1][15:0], 10);
    end
    chk("drained_valid", out_valid, 0);

    got_q.delete();
    pulse(8'b0010_0100);
    cyc(3);
    chk("collide_count", got_q.size(), 1);
    if (got_q.size() >= 1) chk("collide_note", got_q[0][18:16], 2);
    chk("collide_flag", collide, 1);

    rr = 1'b0; clr = 1'b1; cyc(); clr = 1'b0;
    cyc(2);
    repeat (17) pulse(onehot());
    cyc(2);
    chk("fill_count", count, 16);
    chk("fill_full", full, 1);
    chk("fill_ovf", overflow, 1);
    clr = 1'b1; cyc(); clr = 1'b0;
    chk("clear_count", count, 0);
    chk("clear_ovf", overflow, 0);

    cyc(2);
    repeat (16) pulse(onehot());
    chk("refill_ovf", overflow, 0);
    kp = 8'h80; rr = 1'b1; cyc(); kp = '0; rr = 1'b0;
    chk("pushpop_count", count, 16);
    chk("pushpop_ovf", overflow, 0);
    got_q.delete();
    drain("tail");
    chk("tail_entries", got_q.size(), 16);
    if (got_q.size() > 0) chk("tail_note", got_q[got_q.size()-1][18:16], 7);

    rec_en = 1'b0; cyc();
    repeat (5) pulse(onehot());
    chk("idle_count", count, 0);
    rec_en = 1'b1; rr = 1'b0; cyc(2);
    repeat (5) pulse(onehot());
    chk("pre_rst_count", count, 5);
    rst = 1'b1;
    #1;
    chk("async_count", count, 0);
    chk("async_valid", out_valid, 0);
    cyc(2);
    rst = 1'b0;
    cyc(3);

    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 9);
      if (r < 6)      kp = '0;
      else if (r < 9) kp = onehot();
      else            kp = NK'($urandom);
      rr = ($urandom_range(0, 99) < (i < 1500 ? 25 : 70));
      if ($urandom_range(0, 59) == 0) rec_en = ~rec_en;
      clr = ($urandom_range(0, 249) == 0);
      cyc();
    end
    kp = '0; clr = 1'b0; rec_en = 1'b0;
    drain("final");
    chk("sb_leftover", exp_q.size(), 0);

    s_rec = 1'b1; cyc(2);
    s_kp = 8'h02; cyc(); s_kp = '0;
    cyc(100);
    s_kp = 8'h40; cyc(); s_kp = '0;
    cyc(2);
    chk("sat_count", s_count, 2);
    chk("sat_first_note", s_note, 1);
    chk("sat_first_gap", s_gap, 0);
    s_rr = 1'b1; cyc(); s_rr = 1'b0;
    chk("sat_note", s_note, 6);
    chk("sat_gap", s_gap, 15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
